// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port of the multicycle MIPS system between
// two requesters: port 0 (core fetch / load-store) and port 1 (program loader
// or debug master). One transaction per cycle is forwarded to memory. Each
// owner's burst is bounded while the other port waits. Read data is steered
// back to the issuing port RD_LAT cycles after the grant.
//
// Handshake: a port raises req and holds req/wr/addr/wdata stable. The
// transaction transfers in the cycle where req & gnt are both high. gnt is
// combinational from req and registered state, so there is zero grant latency.
// At most one gnt is high in any cycle.
//
// Parameters
//   N          data and address width
//   RD_LAT     memory read latency in cycles (1..4)
//   MAX_BURST  consecutive grants to one owner while the other requests (1..15)
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous, active-low reset
//   p0_req/p1_req            port requests a transaction this cycle
//   p0_wr/p1_wr              1 = write, 0 = read
//   p0_addr/p1_addr          byte address
//   p0_wdata/p1_wdata        write data
//   p0_gnt/p1_gnt            transaction accepted this cycle
//   p0_rvalid/p1_rvalid      read data valid for that port
//   p0_rdata/p1_rdata        read data (qualified by rvalid)
//   mem_wr_ena               memory write enable
//   mem_addr/mem_wr_data     memory address / write data (0 when no grant)
//   mem_rd_data              memory read data, valid RD_LAT cycles after addr
//   dbg_state                FSM state: 0 = IDLE, 1 = OWN0, 2 = OWN1
//   dbg_cnt                  grants to the current owner in its burst
//   dbg_last                 most recently granted port
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N         = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic         p1_req,
  input  logic         p0_wr,
  input  logic         p1_wr,
  input  logic [N-1:0] p0_addr,
  input  logic [N-1:0] p1_addr,
  input  logic [N-1:0] p0_wdata,
  input  logic [N-1:0] p1_wdata,
  output logic         p0_gnt,
  output logic         p1_gnt,
  output logic         p0_rvalid,
  output logic         p1_rvalid,
  output logic [N-1:0] p0_rdata,
  output logic [N-1:0] p1_rdata,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  input  logic [N-1:0] mem_rd_data,
  output logic [1:0]   dbg_state,
  output logic [3:0]   dbg_cnt,
  output logic         dbg_last
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       last;
  logic       last_nxt;
  logic       gnt0;
  logic       gnt1;

  // Read-return tag pipeline: entry 0 is the newest, entry RD_LAT-1 the tail.
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_p;
  logic              push_v;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;

    case (state)
      IDLE: begin
        // Contention from idle goes to the port that did not win last.
        if (p0_req && (!p1_req || last)) begin
          gnt0      = 1'b1;
          state_nxt = OWN0;
          cnt_nxt   = 4'd1;
        end else if (p1_req) begin
          gnt1      = 1'b1;
          state_nxt = OWN1;
          cnt_nxt   = 4'd1;
        end
      end

      OWN0: begin
        if (p0_req && ((cnt < MAX_B) || !p1_req)) begin
          gnt0 = 1'b1;
          // A sole requester wraps the counter and keeps streaming.
          cnt_nxt = (cnt < MAX_B) ? cnt + 4'd1 : 4'd1;
        end else if (p1_req) begin
          gnt1      = 1'b1;
          state_nxt = OWN1;
          cnt_nxt   = 4'd1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end

      OWN1: begin
        if (p1_req && ((cnt < MAX_B) || !p0_req)) begin
          gnt1    = 1'b1;
          cnt_nxt = (cnt < MAX_B) ? cnt + 4'd1 : 4'd1;
        end else if (p0_req) begin
          gnt0      = 1'b1;
          state_nxt = OWN0;
          cnt_nxt   = 4'd1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    // Grants are suppressed for the whole reset cycle, not just after it.
    if (!rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    last_nxt = last;
    if (gnt0) last_nxt = 1'b0;
    if (gnt1) last_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Memory drive: everything is gated by the grant so an idle cycle
  // presents zeros to memory.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_wr_ena  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (gnt0) begin
      mem_wr_ena  = p0_wr;
      mem_addr    = p0_addr;
      mem_wr_data = p0_wdata;
    end else if (gnt1) begin
      mem_wr_ena  = p1_wr;
      mem_addr    = p1_addr;
      mem_wr_data = p1_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------
  assign push_v = (gnt0 && !p0_wr) || (gnt1 && !p1_wr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v[0] <= push_v;
      tag_p[0] <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign p0_rvalid = rst && tag_v[RD_LAT-1] && !tag_p[RD_LAT-1];
  assign p1_rvalid = rst && tag_v[RD_LAT-1] &&  tag_p[RD_LAT-1];
  assign p0_rdata  = mem_rd_data;
  assign p1_rdata  = mem_rd_data;

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  assign dbg_state = state;
  assign dbg_cnt   = cnt;
  assign dbg_last  = last;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiters (RD_LAT = 1, 2, 3; MAX_BURST = 4) share one set of request
// inputs. A behavioural model predicts grants from the run length of the
// current owner, keeps a queue of expected read returns per latency, and
// tracks memory contents; every cycle all outputs are compared against it.
// A vector table, hand-written sequences and a random phase drive stimulus.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAX_B = 4;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic        p0_req, p1_req, p0_wr, p1_wr;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;

  // per-instance outputs
  logic [2:0]       g0_v, g1_v, rv0_v, rv1_v, we_v, last_v;
  logic [2:0][31:0] rd0_v, rd1_v, ma_v, mw_v, mrd_v;
  logic [2:0][1:0]  st_v;
  logic [2:0][3:0]  cnt_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.N(32), .RD_LAT(g + 1), .MAX_BURST(MAX_B)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .p0_req     (p0_req),
      .p1_req     (p1_req),
      .p0_wr      (p0_wr),
      .p1_wr      (p1_wr),
      .p0_addr    (p0_addr),
      .p1_addr    (p1_addr),
      .p0_wdata   (p0_wdata),
      .p1_wdata   (p1_wdata),
      .p0_gnt     (g0_v[g]),
      .p1_gnt     (g1_v[g]),
      .p0_rvalid  (rv0_v[g]),
      .p1_rvalid  (rv1_v[g]),
      .p0_rdata   (rd0_v[g]),
      .p1_rdata   (rd1_v[g]),
      .mem_wr_ena (we_v[g]),
      .mem_addr   (ma_v[g]),
      .mem_wr_data(mw_v[g]),
      .mem_rd_data(mrd_v[g]),
      .dbg_state  (st_v[g]),
      .dbg_cnt    (cnt_v[g]),
      .dbg_last   (last_v[g])
    );
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } ret_t;
  ret_t exp_q[3][$];

  // reference model state
  int prev   = -1;   // port granted last cycle, -1 if none
  int streak = 0;    // consecutive grants to prev
  int last_m = 1;    // most recently granted port
  int m_eg   = -1;   // model grant of the latest step

  // memories: physical (driven by the DUT) and expected (driven by the model)
  logic [31:0] mem_phys[logic [31:0]];
  logic [31:0] mem_exp[logic [31:0]];
  logic [31:0] hist[4];

  // values sampled in the latest step
  logic             s_g0, s_g1, s_we;
  logic [31:0]      s_ma;
  logic [3:0]       s_cnt;
  logic [2:0]       s_rv0, s_rv1;
  logic [2:0][31:0] s_rd0, s_rd1;

  function automatic logic [31:0] rd_phys(input logic [31:0] a);
    return mem_phys.exists(a) ? mem_phys[a] : 32'hA0 + a;
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return mem_exp.exists(a) ? mem_exp[a] : 32'hA0 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance at posedge.
  task automatic step(input logic r,
                      input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    int          eg, x, y, evp;
    logic        ew, pw;
    logic [31:0] ea, ed, edata, pa, pd;
    logic        rq[2];
    logic        wq[2];
    logic [31:0] aq[2];
    logic [31:0] dq[2];
    logic [31:0] ex_cnt, ex_st;
    ret_t        h;

    rst = r;
    p0_req = q0; p0_wr = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = q1; p1_wr = w1; p1_addr = a1; p1_wdata = d1;
    for (int k = 0; k < 3; k++) mrd_v[k] = hist[k];
    rq[0] = q0; rq[1] = q1; wq[0] = w0; wq[1] = w1;
    aq[0] = a0; aq[1] = a1; dq[0] = d0; dq[1] = d1;

    @(negedge clk);

    // expected grant from the owner's run length
    eg = -1;
    if (r) begin
      if (prev < 0) begin
        if (q0 && q1) eg = 1 - last_m;
        else if (q0)  eg = 0;
        else if (q1)  eg = 1;
      end else begin
        x = prev;
        y = 1 - prev;
        if (rq[x] && ((streak % MAX_B) != 0 || !rq[y])) eg = x;
        else if (rq[y]) eg = y;
      end
    end
    m_eg = eg;
    ew = (eg >= 0) ? wq[eg] : 1'b0;
    ea = (eg >= 0) ? aq[eg] : 32'h0;
    ed = (eg >= 0) ? dq[eg] : 32'h0;
    ex_cnt = (prev < 0) ? 32'd0 : 32'(((streak - 1) % MAX_B) + 1);
    ex_st  = (prev < 0) ? 32'd0 : 32'(prev + 1);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("gnt0_L%0d", k + 1), 32'(g0_v[k]), 32'(eg == 0));
      check($sformatf("gnt1_L%0d", k + 1), 32'(g1_v[k]), 32'(eg == 1));
      check($sformatf("mem_wr_ena_L%0d", k + 1), 32'(we_v[k]), 32'(ew));
      check($sformatf("mem_addr_L%0d", k + 1), ma_v[k], ea);
      check($sformatf("mem_wr_data_L%0d", k + 1), mw_v[k], ed);
      check($sformatf("cnt_L%0d", k + 1), 32'(cnt_v[k]), ex_cnt);
      check($sformatf("state_L%0d", k + 1), 32'(st_v[k]), ex_st);
      check($sformatf("last_L%0d", k + 1), 32'(last_v[k]), 32'(last_m));

      evp   = -1;
      edata = 32'h0;
      if (exp_q[k].size() > 0) begin
        h = exp_q[k][0];
        if (h.due == cyc) begin
          void'(exp_q[k].pop_front());
          if (r) begin
            evp   = h.port;
            edata = h.data;
          end
        end
      end
      check($sformatf("rvalid0_L%0d", k + 1), 32'(rv0_v[k]), 32'(evp == 0));
      check($sformatf("rvalid1_L%0d", k + 1), 32'(rv1_v[k]), 32'(evp == 1));
      if (evp == 0) check($sformatf("rdata0_L%0d", k + 1), rd0_v[k], edata);
      if (evp == 1) check($sformatf("rdata1_L%0d", k + 1), rd1_v[k], edata);
    end

    s_g0 = g0_v[0]; s_g1 = g1_v[0]; s_we = we_v[0]; s_ma = ma_v[0];
    s_cnt = cnt_v[0]; s_rv0 = rv0_v; s_rv1 = rv1_v; s_rd0 = rd0_v; s_rd1 = rd1_v;
    pw = we_v[0]; pa = ma_v[0]; pd = mw_v[0];

    @(posedge clk);

    // physical memory with RD_LAT history
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = rd_phys(pa);
    if (pw) mem_phys[pa] = pd;

    // model update
    if (!r) begin
      prev = -1; streak = 0; last_m = 1;
      for (int k = 0; k < 3; k++) exp_q[k].delete();
    end else if (eg >= 0) begin
      streak = (eg == prev) ? streak + 1 : 1;
      prev   = eg;
      last_m = eg;
      if (!ew) begin
        for (int k = 0; k < 3; k++)
          exp_q[k].push_back('{due: cyc + k + 1, port: eg, data: rd_exp(ea)});
      end else begin
        mem_exp[ea] = ed;
      end
    end else begin
      prev = -1; streak = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic r, q0, q1, g0, g1;
  } vec_t;
  vec_t vt[18];

  logic        hq[2], hw[2];
  logic [31:0] ha[2], hd[2];
  logic        rr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
    p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    mrd_v = '0;
    for (int i = 0; i < 4; i++) hist[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // --- vector table: reset with contention, burst alternation, idle resume
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 2; i < 6; i++)   vt[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 6; i < 10; i++)  vt[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 10; i < 14; i++) vt[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 18; i++) begin
      step(vt[i].r, vt[i].q0, 1'b0, 32'h20, 32'h0, vt[i].q1, 1'b0, 32'h24, 32'h0);
      check($sformatf("tbl_gnt0[%0d]", i), 32'(s_g0), 32'(vt[i].g0));
      check($sformatf("tbl_gnt1[%0d]", i), 32'(s_g1), 32'(vt[i].g1));
      if (!vt[i].r) check($sformatf("tbl_rst_we[%0d]", i), 32'(s_we), 32'd0);
    end

    // --- p0 back-to-back reads, RD_LAT = 1
    idle();
    step(1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rd_seq_gnt", 32'(s_g0), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rd_seq_rv_a0", 32'(s_rv0[0]), 32'd1);
    check("rd_seq_data_a0", s_rd0[0], 32'hA0);
    step(1'b1, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rd_seq_data_a4", s_rd0[0], 32'hA4);
    idle();
    check("rd_seq_data_a8", s_rd0[0], 32'hA8);
    check("rd_seq_p1_quiet", 32'(s_rv1[0]), 32'd0);
    idle();
    check("rd_seq_done", 32'(s_rv0[0]), 32'd0);

    // --- sole streaming requester wraps the burst counter
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
      check($sformatf("stream_gnt[%0d]", i), 32'(s_g1), 32'd1);
      if (i == 4) check("stream_cnt_full", 32'(s_cnt), 32'd4);
      if (i == 5) check("stream_cnt_wrap", 32'(s_cnt), 32'd1);
    end
    idle();

    // --- p0 write then p1 read of the same address, RD_LAT = 2
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wr_rd_we", 32'(s_we), 32'd1);
    check("wr_rd_addr", s_ma, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("wr_rd_we_off", 32'(s_we), 32'd0);
    check("wr_rd_gnt1", 32'(s_g1), 32'd1);
    idle();
    check("wr_rd_early", 32'(s_rv1[1]), 32'd0);
    idle();
    check("wr_rd_rv", 32'(s_rv1[1]), 32'd1);
    check("wr_rd_data", s_rd1[1], 32'h1234);
    check("wr_rd_no_p0", 32'(s_rv0[1]), 32'd0);
    idle();

    // --- reset while a read is in flight, RD_LAT = 3
    step(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check($sformatf("rst_drop[%0d]", i), 32'(s_rv0[2]), 32'd0);
    end

    // --- randomized traffic, requests held until granted
    for (int p = 0; p < 2; p++) hq[p] = 1'b0;
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hq[p]) begin
          hq[p] = ($urandom_range(0, 99) < 60);
          hw[p] = ($urandom_range(0, 2) == 0);
          ha[p] = 32'($urandom_range(0, 15)) * 32'd4;
          hd[p] = $urandom;
        end
      end
      rr = ($urandom_range(0, 99) != 0);
      step(rr, hq[0], hw[0], ha[0], hd[0], hq[1], hw[1], ha[1], hd[1]);
      for (int p = 0; p < 2; p++)
        if (!rr || m_eg == p) hq[p] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
